// File: rtl/calc_lcd_pkg.sv
// Shared definitions for the calculator LCD scheduler: scan-state encodings,
// HD44780 command bytes and character constants.
package calc_lcd_pkg;

    typedef logic [3:0] scan_state_t;

    localparam scan_state_t ST_PWR_WAIT  = 4'd0;
    localparam scan_state_t ST_FUNC_SET  = 4'd1;
    localparam scan_state_t ST_DISP_ON   = 4'd2;
    localparam scan_state_t ST_ENTRY     = 4'd3;
    localparam scan_state_t ST_CLEAR     = 4'd4;
    localparam scan_state_t ST_CLR_WAIT  = 4'd5;
    localparam scan_state_t ST_SET_ADDR1 = 4'd6;
    localparam scan_state_t ST_LINE1     = 4'd7;
    localparam scan_state_t ST_SET_ADDR2 = 4'd8;
    localparam scan_state_t ST_LINE2     = 4'd9;

    localparam logic [7:0] CMD_FUNC_SET  = 8'h3C;
    localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
    localparam logic [7:0] CMD_ENTRY     = 8'h06;
    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_SET_ADDR1 = 8'h80;
    localparam logic [7:0] CMD_SET_ADDR2 = 8'hC0;

    localparam logic [7:0] LCD_BLANK        = 8'h20;
    localparam logic [7:0] ASCII_DIGIT_BASE = 8'h30;

    // Idle slots (power-up and post-clear waits) never strobe E.
    function automatic logic is_strobe_state(input scan_state_t st);
        return (st != ST_PWR_WAIT) && (st != ST_CLR_WAIT);
    endfunction

endpackage

// File: rtl/calc_lcd_scheduler_if.sv
// Character-write request bus between the two requesters and the LCD scheduler.
interface calc_lcd_scheduler_if;
    logic       req0;
    logic [4:0] req0_addr;
    logic [7:0] req0_char;
    logic       gnt0;
    logic       req1;
    logic [4:0] req1_addr;
    logic [7:0] req1_char;
    logic       gnt1;

    modport master (
        output req0, req0_addr, req0_char, req1, req1_addr, req1_char,
        input  gnt0, gnt1
    );

    modport slave (
        input  req0, req0_addr, req0_char, req1, req1_addr, req1_char,
        output gnt0, gnt1
    );
endinterface

// File: rtl/calc_lcd_req_arbiter.sv
// Two-requester buffer-write arbiter. Fixed priority req0 > req1 by default;
// define CALC_LCD_RR_EN for round-robin on contention.
module calc_lcd_req_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [4:0] req0_addr,
    input  logic [7:0] req0_char,
    input  logic       req1,
    input  logic [4:0] req1_addr,
    input  logic [7:0] req1_char,
    output logic       gnt0,
    output logic       gnt1,
    output logic       wr_en,
    output logic [4:0] wr_addr,
    output logic [7:0] wr_char
);

    logic prio0_r;
    logic gnt0_s;
    logic gnt1_s;

    // Contention pointer: 1 favours req0; only moves in round-robin builds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio0_r <= 1'b1;
        end else begin
`ifdef CALC_LCD_RR_EN
            if (gnt0_s) begin
                prio0_r <= 1'b0;
            end else if (gnt1_s) begin
                prio0_r <= 1'b1;
            end
`else
            prio0_r <= 1'b1;
`endif
        end
    end

    // Single grant per cycle, only to an active request.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (req0 && req1) begin
            gnt0_s = prio0_r;
            gnt1_s = !prio0_r;
        end else begin
            gnt0_s = req0;
            gnt1_s = req1;
        end
    end

    assign gnt0    = gnt0_s;
    assign gnt1    = gnt1_s;
    assign wr_en   = gnt0_s | gnt1_s;
    assign wr_addr = gnt1_s ? req1_addr : req0_addr;
    assign wr_char = gnt1_s ? req1_char : req0_char;

endmodule

// File: rtl/calc_lcd_scheduler.sv
// Character-LCD bus owner: power-up init, continuous two-line refresh from a
// 32-byte shadow buffer, arbitrated writes (CALC_LCD_RR_EN selects round-robin).
module calc_lcd_scheduler
    import calc_lcd_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 5,
    parameter int unsigned PWRUP_SLOTS = 70,
    parameter int unsigned CLR_SLOTS   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    calc_lcd_scheduler_if.slave  bus,
    output logic                 ready,
    output logic                 frame_done,
    output logic                 lcd_e,
    output logic                 lcd_rs,
    output logic                 lcd_rw,
    output logic [7:0]           lcd_data
);

    localparam int unsigned SLOT_CLKS = 2 * TICK_DIV;
    localparam int          SDIV_W    = $clog2(SLOT_CLKS);
    localparam int          CNT_W     = 16;
    localparam logic [SDIV_W-1:0] SDIV_LAST  = SDIV_W'(SLOT_CLKS - 1);
    localparam logic [SDIV_W-1:0] SDIV_E_END = SDIV_W'(TICK_DIV);
    localparam logic [CNT_W-1:0]  PWR_LAST   = CNT_W'(PWRUP_SLOTS - 1);
    localparam logic [CNT_W-1:0]  CLR_LAST   = CNT_W'(CLR_SLOTS - 1);
    localparam logic [CNT_W-1:0]  COL_LAST   = CNT_W'(15);

    logic [SDIV_W-1:0] sdiv_r;
    logic [SDIV_W-1:0] sdiv_nxt_s;
    logic              slot_end_s;
    scan_state_t       state_r;
    scan_state_t       state_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic [7:0]        buf_r [32];
    logic              wr_en_s;
    logic [4:0]        wr_addr_s;
    logic [7:0]        wr_char_s;
    logic [4:0]        rd_addr_s;
    logic              ld_valid_s;
    logic              ld_rs_s;
    logic [7:0]        ld_data_s;
    logic              lcd_e_r;
    logic              lcd_rs_r;
    logic [7:0]        lcd_data_r;
    logic              ready_r;
    logic              frame_done_r;

    calc_lcd_req_arbiter u_arb (
        .clk       (clk),
        .rst       (rst),
        .req0      (bus.req0),
        .req0_addr (bus.req0_addr),
        .req0_char (bus.req0_char),
        .req1      (bus.req1),
        .req1_addr (bus.req1_addr),
        .req1_char (bus.req1_char),
        .gnt0      (bus.gnt0),
        .gnt1      (bus.gnt1),
        .wr_en     (wr_en_s),
        .wr_addr   (wr_addr_s),
        .wr_char   (wr_char_s)
    );

    assign slot_end_s = (sdiv_r == SDIV_LAST);
    assign sdiv_nxt_s = slot_end_s ? '0 : sdiv_r + SDIV_W'(1);

    // Scan sequence advance at each slot boundary.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        if (slot_end_s) begin
            case (state_r)
                ST_PWR_WAIT: begin
                    if (cnt_r == PWR_LAST) begin
                        state_nxt_s = ST_FUNC_SET;
                        cnt_nxt_s   = '0;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_W'(1);
                    end
                end
                ST_FUNC_SET:  state_nxt_s = ST_DISP_ON;
                ST_DISP_ON:   state_nxt_s = ST_ENTRY;
                ST_ENTRY:     state_nxt_s = ST_CLEAR;
                ST_CLEAR: begin
                    state_nxt_s = ST_CLR_WAIT;
                    cnt_nxt_s   = '0;
                end
                ST_CLR_WAIT: begin
                    if (cnt_r == CLR_LAST) begin
                        state_nxt_s = ST_SET_ADDR1;
                        cnt_nxt_s   = '0;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_W'(1);
                    end
                end
                ST_SET_ADDR1: begin
                    state_nxt_s = ST_LINE1;
                    cnt_nxt_s   = '0;
                end
                ST_LINE1: begin
                    if (cnt_r == COL_LAST) begin
                        state_nxt_s = ST_SET_ADDR2;
                        cnt_nxt_s   = '0;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_W'(1);
                    end
                end
                ST_SET_ADDR2: begin
                    state_nxt_s = ST_LINE2;
                    cnt_nxt_s   = '0;
                end
                ST_LINE2: begin
                    if (cnt_r == COL_LAST) begin
                        state_nxt_s = ST_SET_ADDR1;
                        cnt_nxt_s   = '0;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt_s = ST_PWR_WAIT;
                    cnt_nxt_s   = '0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
            cnt_nxt_s   = cnt_r;
        end
    end

    // Bus value for the upcoming slot; buffer read sees pre-write contents.
    always_comb begin
        ld_valid_s = 1'b0;
        ld_rs_s    = 1'b0;
        ld_data_s  = 8'h00;
        rd_addr_s  = {(state_nxt_s == ST_LINE2), cnt_nxt_s[3:0]};
        case (state_nxt_s)
            ST_FUNC_SET: begin
                ld_valid_s = 1'b1;
                ld_data_s  = CMD_FUNC_SET;
            end
            ST_DISP_ON: begin
                ld_valid_s = 1'b1;
                ld_data_s  = CMD_DISP_ON;
            end
            ST_ENTRY: begin
                ld_valid_s = 1'b1;
                ld_data_s  = CMD_ENTRY;
            end
            ST_CLEAR: begin
                ld_valid_s = 1'b1;
                ld_data_s  = CMD_CLEAR;
            end
            ST_SET_ADDR1: begin
                ld_valid_s = 1'b1;
                ld_data_s  = CMD_SET_ADDR1;
            end
            ST_SET_ADDR2: begin
                ld_valid_s = 1'b1;
                ld_data_s  = CMD_SET_ADDR2;
            end
            ST_LINE1, ST_LINE2: begin
                ld_valid_s = 1'b1;
                ld_rs_s    = 1'b1;
                ld_data_s  = buf_r[rd_addr_s];
            end
            default: begin
                ld_valid_s = 1'b0;
            end
        endcase
    end

    // Slot timing and scan state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sdiv_r  <= '0;
            state_r <= ST_PWR_WAIT;
            cnt_r   <= '0;
        end else begin
            sdiv_r  <= sdiv_nxt_s;
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // LCD pins and status: rs/data set at slot start, E high for sdiv 1..TICK_DIV.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lcd_e_r      <= 1'b0;
            lcd_rs_r     <= 1'b0;
            lcd_data_r   <= 8'h00;
            ready_r      <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            if (slot_end_s && ld_valid_s) begin
                lcd_rs_r   <= ld_rs_s;
                lcd_data_r <= ld_data_s;
            end
            lcd_e_r      <= is_strobe_state(state_r) && (sdiv_nxt_s != '0) &&
                            (sdiv_nxt_s <= SDIV_E_END);
            frame_done_r <= slot_end_s && (state_r == ST_LINE2) && (cnt_r == COL_LAST);
            ready_r      <= ready_r | (slot_end_s && (state_nxt_s == ST_SET_ADDR1));
        end
    end

    // Shadow buffer, blanked on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                buf_r[i] <= LCD_BLANK;
            end
        end else if (wr_en_s) begin
            buf_r[wr_addr_s] <= wr_char_s;
        end
    end

    assign lcd_e      = lcd_e_r;
    assign lcd_rs     = lcd_rs_r;
    assign lcd_rw     = 1'b0;
    assign lcd_data   = lcd_data_r;
    assign ready      = ready_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_calc_lcd_scheduler.sv
// Directed bench for calc_lcd_scheduler with TICK_DIV=2, PWRUP_SLOTS=4, CLR_SLOTS=2.
module tb_calc_lcd_scheduler;
    localparam int SLOT = 4;

    typedef struct packed {
        logic       valid;
        logic       rs;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        int         cyc;
        logic       rs;
        logic [7:0] data;
    } strobe_t;

    typedef struct {
        logic r0;
        logic r1;
        logic g0;
        logic g1;
    } arb_vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       ready, frame_done, lcd_e, lcd_rs, lcd_rw;
    logic [7:0] lcd_data;

    int n_vec = 0;
    int n_err = 0;
    int k;
    logic e_prev;
    int rise_k;
    logic [8:0] rise_d;
    strobe_t sq[$];
    int fdq[$];
    arb_vec_t arb_tab[8];

    calc_lcd_scheduler_if bus ();

    calc_lcd_scheduler #(.TICK_DIV(2), .PWRUP_SLOTS(4), .CLR_SLOTS(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .ready      (ready),
        .frame_done (frame_done),
        .lcd_e      (lcd_e),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_data   (lcd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (k=%0d)", name, act, exp, k);
        end
    endtask

    // Posedges since reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    // Strobe and frame_done monitor.
    always @(negedge clk) begin
        if (rst) begin
            e_prev <= 1'b0;
        end else begin
            e_prev <= lcd_e;
            if (lcd_e && !e_prev) begin
                sq.push_back('{k, lcd_rs, lcd_data});
                rise_k <= k;
                rise_d <= {lcd_rs, lcd_data};
            end
            if (!lcd_e && e_prev) begin
                check("e_width", k - rise_k, 2);
                check("bus_hold", {lcd_rs, lcd_data}, rise_d);
            end
            if (frame_done) fdq.push_back(k);
        end
    end

    function automatic exp_t slot_exp(input int s, input bit wrote);
        exp_t e;
        int f, r, col;
        bit line;
        e = '{valid: 1'b0, rs: 1'b0, data: 8'h00};
        if (s >= 4 && s <= 7) begin
            e.valid = 1'b1;
            case (s)
                4: e.data = 8'h3C;
                5: e.data = 8'h0C;
                6: e.data = 8'h06;
                default: e.data = 8'h01;
            endcase
        end else if (s >= 10) begin
            f = (s - 10) / 34;
            r = (s - 10) % 34;
            e.valid = 1'b1;
            if (r == 0) begin
                e.data = 8'h80;
            end else if (r == 17) begin
                e.data = 8'hC0;
            end else begin
                e.rs = 1'b1;
                line = (r > 17);
                col = line ? r - 18 : r - 1;
                e.data = 8'h20;
                if (wrote) begin
                    if (!line && col == 0) e.data = 8'h37;
                    if (line && col == 2) e.data = 8'h35;
                    if (!line && col == 5 && f >= 1) e.data = 8'h2B;
                end
            end
        end
        return e;
    endfunction

    task automatic wait_k(input int t);
        int g = 0;
        while (k < t && g < 5000) begin
            @(negedge clk);
            g++;
        end
        if (k != t) check("wait_k", k, t);
    endtask

    task automatic compare_strobes(input int n_slots, input bit wrote);
        exp_t e;
        strobe_t got;
        for (int s = 0; s < n_slots; s++) begin
            e = slot_exp(s, wrote);
            if (e.valid) begin
                if (sq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL strobe_missing: slot %0d got none, expected data %0h", s, e.data);
                end else begin
                    got = sq.pop_front();
                    check($sformatf("strobe_cyc[%0d]", s), got.cyc, SLOT * s + 1);
                    check($sformatf("strobe_rs[%0d]", s), got.rs, e.rs);
                    check($sformatf("strobe_data[%0d]", s), got.data, e.data);
                end
            end
        end
        check("strobe_extra", sq.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_e"}, lcd_e, 1'b0);
        check({tag, "_rs"}, lcd_rs, 1'b0);
        check({tag, "_rw"}, lcd_rw, 1'b0);
        check({tag, "_data"}, lcd_data, 8'h00);
        check({tag, "_gnt0"}, bus.gnt0, 1'b0);
        check({tag, "_gnt1"}, bus.gnt1, 1'b0);
        check({tag, "_ready"}, ready, 1'b0);
        check({tag, "_frame_done"}, frame_done, 1'b0);
    endtask

    initial begin
        arb_tab[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
        arb_tab[1] = '{1'b1, 1'b1, 1'b1, 1'b0};
`ifdef CALC_LCD_RR_EN
        arb_tab[2] = '{1'b1, 1'b1, 1'b0, 1'b1};
        arb_tab[3] = '{1'b1, 1'b1, 1'b1, 1'b0};
        arb_tab[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
`else
        arb_tab[2] = '{1'b1, 1'b1, 1'b1, 1'b0};
        arb_tab[3] = '{1'b1, 1'b1, 1'b1, 1'b0};
        arb_tab[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
`endif
        arb_tab[5] = '{1'b0, 1'b1, 1'b0, 1'b1};
        arb_tab[6] = '{1'b1, 1'b0, 1'b1, 1'b0};
        arb_tab[7] = '{1'b0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        bus.req0 = 1'b0; bus.req0_addr = 5'h00; bus.req0_char = 8'h00;
        bus.req1 = 1'b0; bus.req1_addr = 5'h00; bus.req1_char = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;

        // Simultaneous requests during init: req0 first, req1 next cycle.
        wait_k(20);
        bus.req0 = 1'b1; bus.req0_addr = 5'h00; bus.req0_char = 8'h37;
        bus.req1 = 1'b1; bus.req1_addr = 5'h12; bus.req1_char = 8'h35;
        #1;
        check("pri_gnt0_c0", bus.gnt0, 1'b1);
        check("pri_gnt1_c0", bus.gnt1, 1'b0);
        @(negedge clk);
        bus.req0 = 1'b0;
        #1;
        check("pri_gnt0_c1", bus.gnt0, 1'b0);
        check("pri_gnt1_c1", bus.gnt1, 1'b1);
        @(negedge clk);
        bus.req1 = 1'b0;
        #1;
        check("pri_idle_gnt0", bus.gnt0, 1'b0);
        check("pri_idle_gnt1", bus.gnt1, 1'b0);

        wait_k(39);
        check("ready_before", ready, 1'b0);
        wait_k(40);
        check("ready_at_addr1", ready, 1'b1);

        // Write col5 in the cycle its first-frame value is captured.
        wait_k(63);
        bus.req1 = 1'b1; bus.req1_addr = 5'h05; bus.req1_char = 8'h2B;
        #1;
        check("rbw_gnt1", bus.gnt1, 1'b1);
        @(negedge clk);
        bus.req1 = 1'b0;

        wait_k(208);
        compare_strobes(52, 1'b1);
        check("frame_done_count", fdq.size(), 1);
        if (fdq.size() > 0) check("frame_done_cyc", fdq[0], 176);
        check("ready_sticky", ready, 1'b1);

        // Reset in the middle of a LINE1 strobe.
        wait_k(210);
        check("pre_rst_e", lcd_e, 1'b1);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        sq.delete();
        fdq.delete();
        @(negedge clk);
        rst = 1'b0;

        // Arbitration table; pointer fresh from reset.
        wait_k(10);
        for (int i = 0; i < 8; i++) begin
            bus.req0 = arb_tab[i].r0; bus.req0_addr = 5'h1F; bus.req0_char = 8'h20;
            bus.req1 = arb_tab[i].r1; bus.req1_addr = 5'h1E; bus.req1_char = 8'h20;
            #1;
            check($sformatf("arb_gnt0[%0d]", i), bus.gnt0, arb_tab[i].g0);
            check($sformatf("arb_gnt1[%0d]", i), bus.gnt1, arb_tab[i].g1);
            @(negedge clk);
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;

        wait_k(124);
        compare_strobes(31, 1'b0);
        check("frame_done_after_rst", fdq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
